// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad front-end and the passcode checker.
//   Keeping the state type, column reset value and key encoding here means
//   both sides always agree on how a digit is represented.
//   Contents:
//     scan_state_t  - scanner FSM states
//     COL_RESET     - column drive after reset (col_idx 0)
//     key_code_t    - {row_idx[1:0], col_idx[1:0]}
//     onehot2idx()  - 4'b1000 -> 0, 4'b0100 -> 1, 4'b0010 -> 2, 4'b0001 -> 3
//     col_rotate()  - next column in the sweep (rotate right)
package keypad_pkg;

    typedef enum logic [1:0] {
        SETTLE   = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b1000;

    typedef logic [3:0] key_code_t;

    // MSB-first one-hot to index; a non-one-hot input maps to 0 (callers only
    // pass values already qualified as one-hot).
    function automatic logic [1:0] onehot2idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            4'b0001: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] col_rotate(input logic [3:0] c);
        return {c[0], c[3:1]};
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync
//   Two-flop synchroniser for the raw keypad row lines, one independent
//   chain per bit.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset, clears both stages
//     d_i    in   W raw inputs, asynchronous to clk
//     q_o    out  W synchronised outputs (two-cycle latency)
module keypad_row_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic meta_q;
        logic sync_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q <= 1'b0;
                sync_q <= 1'b0;
            end else begin
                meta_q <= d_i[gi];
                sync_q <= meta_q;
            end
        end

        assign q_o[gi] = sync_q;
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   4x4 keypad front-end: sweeps the columns, synchronises and debounces the
//   row lines and produces one key event per physical press.
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     row        in   4 raw row lines, active-high, asynchronous
//     col        out  one-hot column drive, 4'b1000 = col_idx 0
//     key_valid  out  one-cycle strobe when a debounced press is accepted
//     key_code   out  {row_idx, col_idx} of the last accepted key, held
//     key_held   out  high from key_valid until the debounced release
//     multi_err  out  one-cycle strobe when a sample shows several rows
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic      key_valid,
    output key_code_t key_code,
    output logic      key_held,
    output logic      multi_err
);

    localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [3:0] row_s;

    keypad_row_sync #(.W(4)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row),
        .q_o   (row_s)
    );

    scan_state_t   state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [3:0]    col_q,       col_d;
    logic [3:0]    lat_row_q,   lat_row_d;
    logic          key_valid_q, key_valid_d;
    key_code_t     key_code_q,  key_code_d;
    logic          key_held_q,  key_held_d;
    logic          multi_err_q, multi_err_d;

    logic [CW-1:0] cnt_inc;
    logic          row_zero;
    logic          row_multi;

    // Counter saturates rather than wrapping so a stuck state can never
    // alias back to an early count.
    assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
    assign row_zero  = (row_s == 4'b0000);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign row_multi = ((row_s & (row_s - 4'd1)) != 4'b0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SETTLE;
            cnt_q       <= '0;
            col_q       <= COL_RESET;
            lat_row_q   <= 4'b0000;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'b0000;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            lat_row_q   <= lat_row_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            multi_err_q <= multi_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        lat_row_d   = lat_row_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        multi_err_d = 1'b0;

        case (state_q)
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (row_zero) begin
                        col_d = col_rotate(col_q);
                    end else if (row_multi) begin
                        multi_err_d = 1'b1;
                        col_d       = col_rotate(col_q);
                    end else begin
                        lat_row_d = row_s;
                        state_d   = DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            DEBOUNCE: begin
                if (row_s != lat_row_q) begin
                    // Bounce: resettle the same column before trying again.
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d       = '0;
                    state_d     = PRESSED;
                    key_valid_d = 1'b1;
                    key_code_d  = {onehot2idx(lat_row_q), onehot2idx(col_q)};
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            PRESSED: begin
                // Any row activity (including a second key on this column)
                // just keeps the key held.
                if (row_zero) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (!row_zero) begin
                    cnt_d   = '0;
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    col_d      = col_rotate(col_q);
                    state_d    = SETTLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
        endcase
    end

    assign col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;

    localparam int S = 2;
    localparam int D = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row   = 4'b0000;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_err;

    always #5 clk = ~clk;

    keypad_scan_debounce #(
        .SETTLE_CYC   (S),
        .DEBOUNCE_CYC (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    int total = 0;
    int bad   = 0;

    // Event monitor: counts strobes at every falling edge.
    int kv_count   = 0;
    int me_count   = 0;
    int both_count = 0;

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_count++;
        if (multi_err === 1'b1) me_count++;
        if (key_valid === 1'b1 && multi_err === 1'b1) both_count++;
    end

    // Reference: key position -> code, computed from the matrix geometry.
    function automatic int idx_of(input logic [3:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (oh[3-i]) r = i;
        return r;
    endfunction

    function automatic logic [3:0] exp_code(input logic [3:0] r, input logic [3:0] c);
        return 4'(idx_of(r) * 4 + idx_of(c));
    endfunction

    function automatic logic [3:0] rotr(input logic [3:0] c);
        return {c[0], c[3:1]};
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    // Advance to just after a falling edge, well away from the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the first cycle in which column c starts being driven.
    task automatic wait_col_entry(input logic [3:0] c, input string tag);
        int g;
        g = 0;
        while (col === c && g < 40) begin tick(1); g++; end
        while (col !== c && g < 40) begin tick(1); g++; end
        check({tag, "_col_entry"}, (g < 40), 1);
    endtask

    // Present row r shortly before column c is sampled and expect one event.
    task automatic press(input logic [3:0] r, input logic [3:0] c, input string tag);
        int kv0;
        int w;
        wait_col_entry(rotl(c), tag);
        row = r;
        kv0 = kv_count;
        w   = 0;
        while (kv_count == kv0 && w < 40) begin tick(1); w++; end
        check({tag, "_strobe"}, kv_count - kv0, 1);
        check({tag, "_code"}, key_code, exp_code(r, c));
        check({tag, "_held"}, key_held, 1);
    endtask

    task automatic release_key(input logic [3:0] c, input string tag, output int waited);
        row    = 4'b0000;
        waited = 0;
        while (key_held === 1'b1 && waited < 40) begin tick(1); waited++; end
        check({tag, "_released"}, key_held, 0);
        check({tag, "_rescan_col"}, col, rotr(c));
    endtask

    initial begin
        int         kv0;
        int         me0;
        int         w;
        int         lat;
        int         low_cnt;
        int         changes;
        int         hold;
        logic [3:0] c_exp;
        logic [3:0] prev_col;
        logic [3:0] kr [10];
        logic [3:0] kc [10];

        // ---------------- 1: reset values and idle sweep ----------------
        tick(3);
        check("rst_col",       col,       4'b1000);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code",  key_code,  0);
        check("rst_key_held",  key_held,  0);
        check("rst_multi_err", multi_err, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            c_exp = 4'b1000;
            c_exp = c_exp >> ((k / 2) % 4);
            check($sformatf("idle_col_%0d", k), col, c_exp);
            tick(1);
        end
        check("idle_no_strobe", kv_count, 0);
        check("idle_no_multi",  me_count, 0);

        // ---------------- 2: clean press of digit 6 ----------------
        press(4'b0100, 4'b0010, "t2");
        kv0     = kv_count;
        low_cnt = 0;
        repeat (40) begin
            tick(1);
            if (key_held !== 1'b1) low_cnt++;
        end
        check("t2_held_through", low_cnt, 0);
        check("t2_single_strobe", kv_count - kv0, 0);
        check("t2_valid_low", key_valid, 0);
        release_key(4'b0010, "t2", w);
        check("t2_release_lat", (w >= D + 2 && w <= D + 4), 1);
        check("t2_code_kept", key_code, 4'b0110);

        // ---------------- 3: bouncy press and release ----------------
        wait_col_entry(4'b0100, "t3");
        kv0 = kv_count;
        for (int p = 0; p < 6; p++) begin
            row = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            tick(2);
        end
        check("t3_no_early_strobe", kv_count - kv0, 0);
        row = 4'b0100;
        lat = 0;
        while (kv_count == kv0 && lat < 40) begin tick(1); lat++; end
        check("t3_strobe", kv_count - kv0, 1);
        check("t3_latency", (lat >= D && lat <= S + D + 4), 1);
        check("t3_code", key_code, exp_code(4'b0100, 4'b0010));
        tick(10);
        for (int p = 0; p < 6; p++) begin
            row = (p % 2 == 0) ? 4'b0000 : 4'b0100;
            tick(2);
        end
        check("t3_held_in_bounce", key_held, 1);
        release_key(4'b0010, "t3", w);
        check("t3_one_strobe_total", kv_count - kv0, 1);

        // ---------------- 4: multi-row sample ----------------
        kv0 = kv_count;
        row = 4'b1010;
        tick(4);
        me0      = me_count;
        changes  = 0;
        prev_col = col;
        repeat (16) begin
            tick(1);
            if (col !== prev_col) changes++;
            prev_col = col;
        end
        check("t4_multi_pulses", me_count - me0, 8);
        check("t4_col_advances", changes, 8);
        check("t4_no_strobe", kv_count - kv0, 0);
        row = 4'b0000;
        tick(6);

        // ---------------- 5: entry sequence 1,8,6,5 + random keys ----------------
        kr[0] = 4'b1000; kc[0] = 4'b1000;
        kr[1] = 4'b0010; kc[1] = 4'b0100;
        kr[2] = 4'b0100; kc[2] = 4'b0010;
        kr[3] = 4'b0100; kc[3] = 4'b0100;
        for (int i = 4; i < 10; i++) begin
            c_exp = 4'b1000;
            kr[i] = c_exp >> $urandom_range(0, 3);
            kc[i] = c_exp >> $urandom_range(0, 3);
        end
        for (int i = 0; i < 10; i++) begin
            press(kr[i], kc[i], $sformatf("t5_key%0d", i));
            kv0  = kv_count;
            me0  = me_count;
            hold = $urandom_range(3, 12);
            tick(2);
            // Second key on the frozen column must be ignored.
            if (kr[i] == 4'b1000) row = 4'b1001;
            else                  row = kr[i] | 4'b1000;
            tick(hold);
            check($sformatf("t5_key%0d_no_repeat", i), kv_count - kv0, 0);
            check($sformatf("t5_key%0d_no_multi", i),  me_count - me0, 0);
            release_key(kc[i], $sformatf("t5_key%0d", i), w);
            tick($urandom_range(0, 5));
        end

        // ---------------- 6: reset mid-debounce and mid-press ----------------
        wait_col_entry(4'b1000, "t6a");
        row = 4'b0010;
        kv0 = kv_count;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("t6a_col",  col,       4'b1000);
        check("t6a_kv",   key_valid, 0);
        check("t6a_held", key_held,  0);
        check("t6a_code", key_code,  0);
        check("t6a_me",   multi_err, 0);
        tick(5);
        row   = 4'b0000;
        rst_n = 1'b1;
        tick(20);
        check("t6a_no_strobe", kv_count - kv0, 0);

        press(4'b0001, 4'b0001, "t6b");
        kv0 = kv_count;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("t6b_col",  col,       4'b1000);
        check("t6b_kv",   key_valid, 0);
        check("t6b_held", key_held,  0);
        check("t6b_code", key_code,  0);
        tick(3);
        row   = 4'b0000;
        rst_n = 1'b1;
        tick(20);
        check("t6b_no_strobe", kv_count - kv0, 0);
        check("t6b_held_after", key_held, 0);

        check("never_kv_and_multi", both_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
